decode_stage_hz: RTL and testbench
==================================

Name: decode_stage_hz

Overview:
Parametrised successor to the current decode stage. It holds the architectural register file with a write-first bypass and performs load-use hazard detection. It also generates stall requests, inserts bubbles and flushes, and carries a valid bit through the ID/EX pipeline register. It sits between the IF/ID register and the execute stage. The control bundle and immediate are decoded upstream and arrive as inputs.

Parameters:
XLEN, 32, data/PC width
NREGS, 32, register count; AW = $clog2(NREGS)
CTRL_W, 10, control-bundle width; bit 0 = reg_write, bit 1 = mem_write (fixed positions)

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-high)
instr_d  in  32  instruction in D; rs1=[19:15], rs2=[24:20], rd=[11:7] (low AW bits used)
valid_d  in  1  D holds a real instruction
pc_d, pc_plus4_d  in  XLEN  PC and PC+4 of the D instruction
ctrl_d  in  CTRL_W  decoded control bundle
imm_d  in  XLEN  extended immediate
ld_d  in  1  D instruction is a load
uses_rs1_d, uses_rs2_d  in  1  D instruction reads rs1 / rs2
we_w  in  1  writeback enable
rd_w  in  AW  writeback destination
result_w  in  XLEN  writeback data
flush_e  in  1  kill the instruction entering E (taken branch/jump)
stall_d  out  1  hazard stall request to PC/IF-ID (combinational)
valid_e, ld_e  out  1  E-stage valid / load flag
ctrl_e  out  CTRL_W  registered control bundle
rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e  out  XLEN  registered operands
rs1_e, rs2_e, rd_e  out  AW  registered register indices

Behaviour:
- Reset (async): all E outputs 0; all NREGS registers cleared to 0. stall_d = 0 while valid_e = 0.
- Register file:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write occurs at posedge clk when we_w && rd_w != 0.
  - Reads are combinational with write-first bypass: if we_w && rd_w == ra && ra != 0, the read returns result_w.
- Hazard: haz = valid_d && valid_e && ld_e && rd_e != 0 && ((uses_rs1_d && rs1 == rd_e) || (uses_rs2_d && rs2 == rd_e)).
- stall_d = haz && !flush_e.
- ID/EX update each posedge, in priority order:
  1. flush_e: valid_e = 0, ctrl_e = 0, ld_e = 0; data fields hold.
  2. haz: bubble; same clearing as flush. Upstream holds D, so the instruction re-presents next cycle.
  3. !valid_d: valid_e = 0, ctrl_e = 0, ld_e = 0; data fields captured.
  4. Otherwise: all fields captured, valid_e = 1.
- Latency: D to E is 1 cycle.
- A bubble never has reg_write or mem_write set.
- A stall lasts exactly one cycle per load-use pair, because the bubble clears ld_e.
- Reset asserted mid-stall: outputs clear immediately and stall_d drops.

Optional Feature:
Macro DECODE_STAT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], saturating counters.
  - stall_cnt increments each cycle stall_d = 1.
  - flush_cnt increments each cycle flush_e && valid_d.
  - Both reset to 0 on rst.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package decode_pkg holds:
  - defaults for XLEN, NREGS, CTRL_W
  - ctrl bit indices CTRL_REGWRITE = 0, CTRL_MEMWRITE = 1
  - instruction field LSB/MSB constants for rs1/rs2/rd
- Sub-module reg_file_bypass contains the register array, x0 rule, write-first bypass and async clear, with two read ports and one write port.
- Hazard logic and the ID/EX register stay in the top level.

Test Plan:
- Reset: assert rst mid-run -> all E outputs 0 and stall_d = 0 asynchronously; after release, reading x5 returns 0.
- Bypass: we_w=1, rd_w=5, result_w=0xDEADBEEF in the same cycle as a valid D instruction with rs1=5 -> rd1_e=0xDEADBEEF after 1 cycle.
- x0: we_w=1, rd_w=0, result_w=0x1234, then read rs2=0 -> rd2_e=0.
- Load-use: E holds a valid load with rd_e=7; D valid with uses_rs2_d=1 and rs2=7 -> stall_d=1; next cycle valid_e=0, ctrl_e=0, stall_d=0; following cycle the D instruction is captured with valid_e=1.
- Flush over hazard: same setup plus flush_e=1 -> stall_d=0; next cycle valid_e=0, ctrl_e=0, ld_e=0.
- Stats (DECODE_STAT_EN): 3 load-use stalls and 2 flushes with valid_d -> stall_cnt=3, flush_cnt=2.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants and types for the decode stage: parameter defaults,
// control-bundle bit positions, instruction field positions and ID/EX update kinds.
package decode_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int CTRL_W_DEF = 10;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;

    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;

    // What the ID/EX register does on the next edge, highest priority first
    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_BUBBLE,
        UPD_IDLE,
        UPD_CAPTURE
    } idex_upd_e;

endpackage

// File: rtl/reg_file_bypass.sv
// Architectural register file: two combinational read ports with write-first
// bypass, one write port, x0 hard-wired to zero, asynchronous clear.
module reg_file_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_ra1,
    input  logic [AW-1:0]   i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && i_wa != '0) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // A same-cycle write wins over the stored value so W->D needs no extra forwarding
    assign o_rd1 = (i_ra1 == '0)              ? '0   :
                   (i_we && i_wa == i_ra1)    ? i_wd : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == '0)              ? '0   :
                   (i_we && i_wa == i_ra2)    ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage: register file read, load-use hazard stall/bubble, flush and ID/EX register.
// Optional macro DECODE_STAT_EN adds saturating stall/flush counters.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int CTRL_W = CTRL_W_DEF,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_instr_d,
    input  logic              i_valid_d,
    input  logic [XLEN-1:0]   i_pc_d,
    input  logic [XLEN-1:0]   i_pc_plus4_d,
    input  logic [CTRL_W-1:0] i_ctrl_d,
    input  logic [XLEN-1:0]   i_imm_d,
    input  logic              i_ld_d,
    input  logic              i_uses_rs1_d,
    input  logic              i_uses_rs2_d,
    input  logic              i_we_w,
    input  logic [AW-1:0]     i_rd_w,
    input  logic [XLEN-1:0]   i_result_w,
    input  logic              i_flush_e,
    output logic              o_stall_d,
    output logic              o_valid_e,
    output logic              o_ld_e,
    output logic [CTRL_W-1:0] o_ctrl_e,
    output logic [XLEN-1:0]   o_rd1_e,
    output logic [XLEN-1:0]   o_rd2_e,
    output logic [XLEN-1:0]   o_imm_e,
    output logic [XLEN-1:0]   o_pc_e,
    output logic [XLEN-1:0]   o_pc_plus4_e,
    output logic [AW-1:0]     o_rs1_e,
    output logic [AW-1:0]     o_rs2_e,
    output logic [AW-1:0]     o_rd_e
`ifdef DECODE_STAT_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
`endif
);

    logic [AW-1:0]     w_rs1;
    logic [AW-1:0]     w_rs2;
    logic [AW-1:0]     w_rd;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;
    logic              w_haz;
    logic              w_unused_instr;
    idex_upd_e         w_upd;

    logic              r_valid_e;
    logic              r_ld_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [XLEN-1:0]   r_rd1_e;
    logic [XLEN-1:0]   r_rd2_e;
    logic [XLEN-1:0]   r_imm_e;
    logic [XLEN-1:0]   r_pc_e;
    logic [XLEN-1:0]   r_pc_plus4_e;
    logic [AW-1:0]     r_rs1_e;
    logic [AW-1:0]     r_rs2_e;
    logic [AW-1:0]     r_rd_e;

    assign w_rs1 = AW'(i_instr_d[RS1_MSB:RS1_LSB]);
    assign w_rs2 = AW'(i_instr_d[RS2_MSB:RS2_LSB]);
    assign w_rd  = AW'(i_instr_d[RD_MSB:RD_LSB]);
    assign w_unused_instr = ^i_instr_d;

    reg_file_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .i_we  (i_we_w),
        .i_wa  (i_rd_w),
        .i_wd  (i_result_w)
    );

    assign w_haz = i_valid_d && r_valid_e && r_ld_e && (r_rd_e != '0) &&
                   ((i_uses_rs1_d && w_rs1 == r_rd_e) ||
                    (i_uses_rs2_d && w_rs2 == r_rd_e));

    // A flush kills the consumer anyway, so there is nothing to stall for
    assign o_stall_d = w_haz && !i_flush_e;

    always_comb begin
        w_upd = UPD_CAPTURE;
        if (i_flush_e) begin
            w_upd = UPD_FLUSH;
        end else if (w_haz) begin
            w_upd = UPD_BUBBLE;
        end else if (!i_valid_d) begin
            w_upd = UPD_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_e <= 1'b0;
            r_ld_e    <= 1'b0;
            r_ctrl_e  <= '0;
        end else if (w_upd == UPD_CAPTURE) begin
            r_valid_e <= 1'b1;
            r_ld_e    <= i_ld_d;
            r_ctrl_e  <= i_ctrl_d;
        end else begin
            r_valid_e <= 1'b0;
            r_ld_e    <= 1'b0;
            r_ctrl_e  <= '0;
        end
    end

    // Data fields hold on flush/bubble and are captured otherwise, even for an idle slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_e      <= '0;
            r_pc_e       <= '0;
            r_pc_plus4_e <= '0;
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
        end else if (w_upd == UPD_IDLE || w_upd == UPD_CAPTURE) begin
            r_rd1_e      <= w_rd1;
            r_rd2_e      <= w_rd2;
            r_imm_e      <= i_imm_d;
            r_pc_e       <= i_pc_d;
            r_pc_plus4_e <= i_pc_plus4_d;
            r_rs1_e      <= w_rs1;
            r_rs2_e      <= w_rs2;
            r_rd_e       <= w_rd;
        end
    end

    assign o_valid_e    = r_valid_e;
    assign o_ld_e       = r_ld_e;
    assign o_ctrl_e     = r_ctrl_e;
    assign o_rd1_e      = r_rd1_e;
    assign o_rd2_e      = r_rd2_e;
    assign o_imm_e      = r_imm_e;
    assign o_pc_e       = r_pc_e;
    assign o_pc_plus4_e = r_pc_plus4_e;
    assign o_rs1_e      = r_rs1_e;
    assign o_rs2_e      = r_rs2_e;
    assign o_rd_e       = r_rd_e;

    bubble_has_no_side_effects: assert property (@(posedge clk) disable iff (rst)
        !r_valid_e |-> (!r_ctrl_e[CTRL_REGWRITE] && !r_ctrl_e[CTRL_MEMWRITE]));

`ifdef DECODE_STAT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall_d && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (i_flush_e && i_valid_d && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_decode_stage_hz.sv
// Randomized + directed bench for decode_stage_hz against an array-based reference model.
// Build with DECODE_STAT_EN defined to also cover the stall/flush counters.
module tb_decode_stage_hz;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int CTRL_W = 10;
    localparam int AW     = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       instrD;
    logic              validD;
    logic [XLEN-1:0]   pcD;
    logic [XLEN-1:0]   pcPlus4D;
    logic [CTRL_W-1:0] ctrlD;
    logic [XLEN-1:0]   immD;
    logic              ldD;
    logic              usesRs1D;
    logic              usesRs2D;
    logic              weW;
    logic [AW-1:0]     rdW;
    logic [XLEN-1:0]   resultW;
    logic              flushE;
    logic              stallD;
    logic              validE;
    logic              ldE;
    logic [CTRL_W-1:0] ctrlE;
    logic [XLEN-1:0]   rd1E;
    logic [XLEN-1:0]   rd2E;
    logic [XLEN-1:0]   immE;
    logic [XLEN-1:0]   pcE;
    logic [XLEN-1:0]   pcPlus4E;
    logic [AW-1:0]     rs1E;
    logic [AW-1:0]     rs2E;
    logic [AW-1:0]     rdE;
`ifdef DECODE_STAT_EN
    logic [31:0]       stallCnt;
    logic [31:0]       flushCnt;
`endif

    always #5 clk = ~clk;

    decode_stage_hz #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_instr_d    (instrD),
        .i_valid_d    (validD),
        .i_pc_d       (pcD),
        .i_pc_plus4_d (pcPlus4D),
        .i_ctrl_d     (ctrlD),
        .i_imm_d      (immD),
        .i_ld_d       (ldD),
        .i_uses_rs1_d (usesRs1D),
        .i_uses_rs2_d (usesRs2D),
        .i_we_w       (weW),
        .i_rd_w       (rdW),
        .i_result_w   (resultW),
        .i_flush_e    (flushE),
        .o_stall_d    (stallD),
        .o_valid_e    (validE),
        .o_ld_e       (ldE),
        .o_ctrl_e     (ctrlE),
        .o_rd1_e      (rd1E),
        .o_rd2_e      (rd2E),
        .o_imm_e      (immE),
        .o_pc_e       (pcE),
        .o_pc_plus4_e (pcPlus4E),
        .o_rs1_e      (rs1E),
        .o_rs2_e      (rs2E),
        .o_rd_e       (rdE)
`ifdef DECODE_STAT_EN
        ,
        .o_stall_cnt  (stallCnt),
        .o_flush_cnt  (flushCnt)
`endif
    );

    // Reference model state: the architectural registers and the expected E stage
    logic [31:0]       mRegs [NREGS];
    logic              mValidE, mLdE, lastStall;
    logic [CTRL_W-1:0] mCtrlE;
    logic [31:0]       mRd1E, mRd2E, mImmE, mPcE, mPcPlus4E;
    logic [4:0]        mRs1E, mRs2E, mRdE;
    int unsigned       mStallCnt, mFlushCnt;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (weW && rdW == ra) return resultW;
        return mRegs[ra];
    endfunction

    function automatic logic modelHaz();
        logic [4:0] s1, s2;
        s1 = instrD[19:15];
        s2 = instrD[24:20];
        return validD && mValidE && mLdE && (mRdE != 5'd0) &&
               ((usesRs1D && s1 == mRdE) || (usesRs2D && s2 == mRdE));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) mRegs[i] = 32'd0;
        mValidE = 0; mLdE = 0; mCtrlE = '0; lastStall = 0;
        mRd1E = 0; mRd2E = 0; mImmE = 0; mPcE = 0; mPcPlus4E = 0;
        mRs1E = 0; mRs2E = 0; mRdE = 0;
        mStallCnt = 0; mFlushCnt = 0;
    endtask

    // One rising edge of the pipeline as the rules describe it
    task automatic modelClock();
        logic haz;
        logic [31:0] v1, v2;
        haz = modelHaz();
        v1  = modelRead(instrD[19:15]);
        v2  = modelRead(instrD[24:20]);
        lastStall = haz && !flushE;
        if (lastStall) mStallCnt++;
        if (flushE && validD) mFlushCnt++;
        if (flushE || haz) begin
            mValidE = 0; mCtrlE = '0; mLdE = 0;
        end else begin
            mRd1E = v1; mRd2E = v2; mImmE = immD; mPcE = pcD; mPcPlus4E = pcPlus4D;
            mRs1E = instrD[19:15]; mRs2E = instrD[24:20]; mRdE = instrD[11:7];
            mValidE = validD;
            mCtrlE  = validD ? ctrlD : '0;
            mLdE    = validD ? ldD : 1'b0;
        end
        if (weW && rdW != 5'd0) mRegs[rdW] = resultW;
    endtask

    task automatic checkState();
        checkOutput("valid_e",    64'(validE),   64'(mValidE));
        checkOutput("ld_e",       64'(ldE),      64'(mLdE));
        checkOutput("ctrl_e",     64'(ctrlE),    64'(mCtrlE));
        checkOutput("rd1_e",      64'(rd1E),     64'(mRd1E));
        checkOutput("rd2_e",      64'(rd2E),     64'(mRd2E));
        checkOutput("imm_e",      64'(immE),     64'(mImmE));
        checkOutput("pc_e",       64'(pcE),      64'(mPcE));
        checkOutput("pc_plus4_e", 64'(pcPlus4E), 64'(mPcPlus4E));
        checkOutput("rs1_e",      64'(rs1E),     64'(mRs1E));
        checkOutput("rs2_e",      64'(rs2E),     64'(mRs2E));
        checkOutput("rd_e",       64'(rdE),      64'(mRdE));
`ifdef DECODE_STAT_EN
        checkOutput("stall_cnt",  64'(stallCnt), 64'(mStallCnt));
        checkOutput("flush_cnt",  64'(flushCnt), 64'(mFlushCnt));
`endif
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge
    task automatic runCycle();
        #1;
        checkOutput("stall_d", 64'(stallD), 64'(modelHaz() && !flushE));
        @(posedge clk);
        modelClock();
        #1;
        checkState();
        @(negedge clk);
    endtask

    task automatic setIdle();
        instrD = 32'd0; validD = 0; pcD = 0; pcPlus4D = 0; ctrlD = '0; immD = 0;
        ldD = 0; usesRs1D = 0; usesRs2D = 0; weW = 0; rdW = '0; resultW = 0; flushE = 0;
    endtask

    task automatic setD(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic isLd, input logic u1, input logic u2);
        instrD = $urandom;
        instrD[19:15] = s1;
        instrD[24:20] = s2;
        instrD[11:7]  = d;
        validD = 1; ldD = isLd; usesRs1D = u1; usesRs2D = u2;
        pcD = $urandom; pcPlus4D = pcD + 32'd4; immD = $urandom; ctrlD = 10'h001;
        flushE = 0; weW = 0;
    endtask

    task automatic applyStimulus(input logic hold);
        if (!hold) begin
            setD(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ctrlD  = 10'($urandom);
            validD = ($urandom_range(0, 9) < 8);
        end
        weW     = 1'($urandom_range(0, 1));
        rdW     = 5'($urandom_range(0, 7));
        resultW = $urandom;
        flushE  = ($urandom_range(0, 9) < 2);
    endtask

    initial begin
        setIdle();
        modelReset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkState();
        checkOutput("reset_stall_d", 64'(stallD), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            applyStimulus(lastStall);
            runCycle();
        end

        setIdle();
        runCycle();

        // Write-first bypass into the D read
        setD(5'd5, 5'd1, 5'd2, 0, 1, 0);
        weW = 1; rdW = 5'd5; resultW = 32'hDEADBEEF;
        runCycle();
        checkOutput("bypass_rd1", 64'(rd1E), 64'hDEADBEEF);

        // Writes to x0 are dropped
        setD(5'd3, 5'd0, 5'd4, 0, 0, 1);
        weW = 1; rdW = 5'd0; resultW = 32'h1234;
        runCycle();
        checkOutput("x0_rd2_bypass", 64'(rd2E), 64'd0);
        weW = 0;
        runCycle();
        checkOutput("x0_rd2_stored", 64'(rd2E), 64'd0);

        // Load-use: one bubble, then the held instruction goes through
        setD(5'd1, 5'd2, 5'd7, 1, 0, 0);
        runCycle();
        checkOutput("lu_load_ld_e", 64'(ldE), 64'd1);
        setD(5'd3, 5'd7, 5'd9, 0, 0, 1);
        ctrlD = 10'h003;
        #1;
        checkOutput("lu_stall", 64'(stallD), 64'd1);
        runCycle();
        checkOutput("lu_bubble_valid", 64'(validE), 64'd0);
        checkOutput("lu_bubble_ctrl", 64'(ctrlE), 64'd0);
        checkOutput("lu_stall_drop", 64'(stallD), 64'd0);
        runCycle();
        checkOutput("lu_issue_valid", 64'(validE), 64'd1);
        checkOutput("lu_issue_rs2", 64'(rs2E), 64'd7);
        checkOutput("lu_issue_ctrl", 64'(ctrlE), 64'h003);

        // Flush takes priority over a hazard
        setD(5'd1, 5'd2, 5'd7, 1, 0, 0);
        runCycle();
        setD(5'd3, 5'd7, 5'd9, 0, 0, 1);
        flushE = 1;
        #1;
        checkOutput("fl_stall", 64'(stallD), 64'd0);
        runCycle();
        checkOutput("fl_valid", 64'(validE), 64'd0);
        checkOutput("fl_ctrl", 64'(ctrlE), 64'd0);
        checkOutput("fl_ld", 64'(ldE), 64'd0);

        // Reset in the middle of a stall
        setD(5'd1, 5'd2, 5'd7, 1, 0, 0);
        runCycle();
        setD(5'd7, 5'd2, 5'd9, 0, 1, 0);
        #1;
        checkOutput("rs_stall_before", 64'(stallD), 64'd1);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rs_stall_after", 64'(stallD), 64'd0);
        checkState();
        @(negedge clk);
        rst = 1'b0;
        setD(5'd5, 5'd0, 5'd1, 0, 1, 0);
        runCycle();
        checkOutput("rs_x5_zero", 64'(rd1E), 64'd0);

`ifdef DECODE_STAT_EN
        rst = 1'b1;
        #1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            setD(5'd1, 5'd2, 5'd6, 1, 0, 0);
            runCycle();
            setD(5'd6, 5'd3, 5'd8, 0, 1, 0);
            runCycle();
            runCycle();
        end
        for (int k = 0; k < 2; k++) begin
            setD(5'd1, 5'd2, 5'd3, 0, 0, 0);
            flushE = 1;
            runCycle();
        end
        checkOutput("stat_stall_cnt", 64'(stallCnt), 64'd3);
        checkOutput("stat_flush_cnt", 64'(flushCnt), 64'd2);
`endif

        for (int i = 0; i < 200; i++) begin
            applyStimulus(lastStall);
            runCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
